// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector load/store unit.
// Holds bus geometry, the LSU state encoding and the beat-selection helper.
package riscv_v_pkg;

    localparam int RISCV_V_MEM_BEAT_WIDTH = 32;
    localparam int RISCV_V_MEM_NUM_BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Lowest pending beat index; beats are issued in ascending order.
    function automatic logic [1:0] first_beat(input logic [3:0] pend);
        logic [1:0] idx;
        priority casez (pend)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/riscv_v_lsu_byte_mask.sv
// Active-byte mask of a 16-byte vector register for unit-stride access.
// A byte is active when it lies in [vstart*eb, min(vl*eb, 16)).
module riscv_v_lsu_byte_mask
    import riscv_v_pkg::*;
(
    input  logic [2:0]  sew,
    input  logic [6:0]  vl,
    input  logic [6:0]  vstart,
    output logic [15:0] byte_mask
);

    logic [15:0] eb;
    logic [15:0] lo;
    logic [15:0] hi_raw;
    logic [15:0] hi;

    always_comb begin
        eb     = 16'd1 << sew;
        lo     = 16'(vstart) * eb;
        hi_raw = 16'(vl) * eb;
        hi     = (hi_raw > 16'd16) ? 16'd16 : hi_raw;
        for (int i = 0; i < 16; i++) begin
            byte_mask[i] = (16'(i) >= lo) && (16'(i) < hi);
        end
    end

endmodule

// File: rtl/riscv_v_lsu.sv
// Vector memory stage: unit-stride loads/stores split into 32-bit bus beats,
// non-memory results forwarded to write-back with one cycle of latency.
module riscv_v_lsu
    import riscv_v_pkg::*;
#(
    parameter int BEAT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_pipe,
    input  logic                    valid_exe,
    input  logic                    is_load_exe,
    input  logic                    is_store_exe,
    input  logic [31:0]             addr_exe,
    input  logic [127:0]            store_data_exe,
    input  logic [127:0]            alu_result_exe,
    input  logic [15:0]             rf_wr_en_exe,
    input  logic [4:0]              rf_wr_addr_exe,
    input  logic [8:0]              vtype_exe,
    input  logic [6:0]              vl_exe,
    input  logic [6:0]              vstart_exe,
    output logic [15:0]             rf_wr_en_mem,
    output logic [4:0]              rf_wr_addr_mem,
    output logic [127:0]            rf_wr_data_mem,
    output logic                    lsu_stall,
    output logic                    misaligned_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [BEAT_WIDTH-1:0]   mem_wdata,
    output logic [BEAT_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [BEAT_WIDTH-1:0]   mem_rdata,
    output lsu_state_t              state_dbg
);

    // Bus handshake: a request is presented with mem_req=1 and held unchanged
    // until the cycle mem_gnt=1; a granted load then waits for exactly one
    // mem_rvalid pulse before the next request, so one transaction is in flight.

    lsu_state_t state_q, state_d;

    logic [31:0]           base_q;
    logic [127:0]          sdata_q;
    logic [127:0]          ldata_q;
    logic [15:0]           mask_q;
    logic [3:0]            pend_q;
    logic                  is_store_q;
    logic [4:0]            dest_q;

    logic [15:0]           new_mask;
    logic [3:0]            new_pend;
    logic                  accept;
    logic                  is_mem;
    logic                  misaligned;
    logic                  mem_go;
    logic [1:0]            cur;
    logic [3:0]            cur_oh;
    logic                  more;
    logic [BEAT_WIDTH/8-1:0] cur_be;
    logic [BEAT_WIDTH-1:0] cur_word;
    logic [127:0]          ldata_merged;
    logic                  unused_vtype;

    assign unused_vtype = ^{vtype_exe[8:6], vtype_exe[2:0]};

    riscv_v_lsu_byte_mask u_byte_mask (
        .sew       (vtype_exe[5:3]),
        .vl        (vl_exe),
        .vstart    (vstart_exe),
        .byte_mask (new_mask)
    );

    always_comb begin
        accept     = (state_q == IDLE) && valid_exe && !clear_pipe;
        is_mem     = is_load_exe || is_store_exe;
        misaligned = (addr_exe[1:0] != 2'b00);
        for (int k = 0; k < RISCV_V_MEM_NUM_BEATS; k++) begin
            new_pend[k] = |new_mask[4*k +: 4];
        end
        mem_go   = accept && is_mem && !misaligned && (new_pend != 4'd0);
        cur      = first_beat(pend_q);
        cur_oh   = 4'b0001 << cur;
        more     = |(pend_q & ~cur_oh);
        cur_be   = mask_q[4*int'(cur) +: 4];
        cur_word = sdata_q[32*int'(cur) +: BEAT_WIDTH];
        ldata_merged = ldata_q;
        for (int b = 0; b < BEAT_WIDTH/8; b++) begin
            if (cur_be[b]) begin
                ldata_merged[32*int'(cur) + 8*b +: 8] = mem_rdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_go) state_d = REQ;
            REQ:     if (mem_gnt) state_d = is_store_q ? (more ? REQ : IDLE) : WAIT;
            WAIT:    if (mem_rvalid) state_d = more ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state_dbg = state_q;
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) && is_store_q;
        mem_addr  = (state_q == REQ) ? (base_q + {28'd0, cur, 2'b00}) : 32'd0;
        mem_be    = (state_q == REQ) ? cur_be : '0;
        mem_wdata = ((state_q == REQ) && is_store_q) ? cur_word : '0;
        lsu_stall = (state_q == REQ) || (state_q == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= '0;
            sdata_q        <= '0;
            ldata_q        <= '0;
            mask_q         <= '0;
            pend_q         <= '0;
            is_store_q     <= 1'b0;
            dest_q         <= '0;
            rf_wr_en_mem   <= '0;
            rf_wr_addr_mem <= '0;
            rf_wr_data_mem <= '0;
            misaligned_err <= 1'b0;
        end else begin
            rf_wr_en_mem   <= '0;
            rf_wr_addr_mem <= '0;
            rf_wr_data_mem <= '0;
            misaligned_err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            rf_wr_en_mem   <= rf_wr_en_exe;
                            rf_wr_addr_mem <= rf_wr_addr_exe;
                            rf_wr_data_mem <= alu_result_exe;
                        end else if (misaligned) begin
                            misaligned_err <= 1'b1;
                        end else begin
                            // An op with no active bytes latches here but never leaves IDLE.
                            base_q     <= addr_exe;
                            sdata_q    <= store_data_exe;
                            mask_q     <= new_mask;
                            pend_q     <= new_pend;
                            is_store_q <= is_store_exe;
                            dest_q     <= rf_wr_addr_exe;
                            ldata_q    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt && is_store_q) begin
                        pend_q <= pend_q & ~cur_oh;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        ldata_q <= ldata_merged;
                        pend_q  <= pend_q & ~cur_oh;
                        if (!more) begin
                            rf_wr_en_mem   <= mask_q;
                            rf_wr_addr_mem <= dest_q;
                            rf_wr_data_mem <= ldata_merged;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_v_lsu.sv
// Scoreboard bench for riscv_v_lsu: a driver issues ops and pushes expected
// bus beats / write-backs, a bus slave answers, and a monitor pops and compares.
module tb_riscv_v_lsu;
    import riscv_v_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_pipe, valid_exe, is_load_exe, is_store_exe;
    logic [31:0]  addr_exe;
    logic [127:0] store_data_exe, alu_result_exe;
    logic [15:0]  rf_wr_en_exe;
    logic [4:0]   rf_wr_addr_exe;
    logic [8:0]   vtype_exe;
    logic [6:0]   vl_exe, vstart_exe;
    logic [15:0]  rf_wr_en_mem;
    logic [4:0]   rf_wr_addr_mem;
    logic [127:0] rf_wr_data_mem;
    logic         lsu_stall, misaligned_err, mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_be;
    logic         mem_gnt, mem_rvalid;
    lsu_state_t   state_dbg;

    riscv_v_lsu #(.BEAT_WIDTH(RISCV_V_MEM_BEAT_WIDTH)) dut (
        .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .valid_exe(valid_exe),
        .is_load_exe(is_load_exe), .is_store_exe(is_store_exe), .addr_exe(addr_exe),
        .store_data_exe(store_data_exe), .alu_result_exe(alu_result_exe),
        .rf_wr_en_exe(rf_wr_en_exe), .rf_wr_addr_exe(rf_wr_addr_exe), .vtype_exe(vtype_exe),
        .vl_exe(vl_exe), .vstart_exe(vstart_exe), .rf_wr_en_mem(rf_wr_en_mem),
        .rf_wr_addr_mem(rf_wr_addr_mem), .rf_wr_data_mem(rf_wr_data_mem),
        .lsu_stall(lsu_stall), .misaligned_err(misaligned_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;
    typedef struct packed {
        logic [15:0]  en;
        logic [4:0]   addr;
        logic [127:0] data;
    } wb_t;

    bus_t       exp_bus_q[$];
    wb_t        exp_wb_q[$];
    logic [0:0] exp_err_q[$];
    int checks = 0;
    int failures = 0;
    int gnt_seen = 0;
    int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- bus slave ----------------
    initial begin
        logic        rd_pending;
        logic [31:0] rd_addr;
        int          gnt_wait, rv_wait;
        logic        rst_s;
        rd_pending = 1'b0; rd_addr = '0; gnt_wait = -1; rv_wait = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (rst_s) begin
                rd_pending = 1'b0; gnt_wait = -1;
            end else if (rd_pending) begin
                if (rv_wait == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mem_word(rd_addr); rd_pending = 1'b0;
                end else rv_wait--;
            end else if (mem_req) begin
                if (gnt_wait < 0) gnt_wait = $urandom_range(gnt_max, gnt_min);
                if (gnt_wait == 0) begin
                    mem_gnt = 1'b1; gnt_wait = -1;
                    if (!mem_we) begin
                        rd_pending = 1'b1; rd_addr = mem_addr; rv_wait = $urandom_range(rv_max, rv_min);
                    end
                end else gnt_wait--;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic [3:0]  prev_be;
        bus_t        eb;
        wb_t         ew;
        prev_hold = 1'b0; prev_addr = '0; prev_be = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (!(mem_req && mem_addr == prev_addr && mem_be == prev_be)) begin
                        failures++;
                        $display("FAIL req_hold req=%b addr=%h be=%h expected req=1 addr=%h be=%h",
                                 mem_req, mem_addr, mem_be, prev_addr, prev_be);
                    end
                end
                if (mem_req && mem_gnt) begin
                    gnt_seen++;
                    checks++;
                    if (exp_bus_q.size() == 0) begin
                        failures++;
                        $display("FAIL bus_unexpected addr=%h be=%h we=%b expected none", mem_addr, mem_be, mem_we);
                    end else begin
                        eb = exp_bus_q.pop_front();
                        if (mem_addr !== eb.addr || mem_be !== eb.be || mem_we !== eb.we ||
                            (eb.we && mem_wdata !== eb.wdata)) begin
                            failures++;
                            $display("FAIL bus_beat actual addr=%h be=%h we=%b wdata=%h expected addr=%h be=%h we=%b wdata=%h",
                                     mem_addr, mem_be, mem_we, mem_wdata, eb.addr, eb.be, eb.we, eb.wdata);
                        end
                    end
                end
                if (rf_wr_en_mem != 16'd0) begin
                    checks++;
                    if (exp_wb_q.size() == 0) begin
                        failures++;
                        $display("FAIL wb_unexpected en=%h addr=%0d expected none", rf_wr_en_mem, rf_wr_addr_mem);
                    end else begin
                        ew = exp_wb_q.pop_front();
                        if (rf_wr_en_mem !== ew.en || rf_wr_addr_mem !== ew.addr || rf_wr_data_mem !== ew.data) begin
                            failures++;
                            $display("FAIL wb actual en=%h addr=%0d data=%h expected en=%h addr=%0d data=%h",
                                     rf_wr_en_mem, rf_wr_addr_mem, rf_wr_data_mem, ew.en, ew.addr, ew.data);
                        end
                    end
                end
                if (misaligned_err) begin
                    checks++;
                    if (exp_err_q.size() == 0) begin
                        failures++;
                        $display("FAIL err_unexpected misaligned_err=1 expected 0");
                    end else void'(exp_err_q.pop_front());
                end
                prev_hold = mem_req && !mem_gnt;
                prev_addr = mem_addr;
                prev_be   = mem_be;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_not_stalled();
        int guard = 0;
        while (lsu_stall && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 500) begin
            failures++; checks++;
            $display("FAIL stall_timeout lsu_stall=1 expected 0 within 500 cycles");
        end
    endtask

    // Presents one op for a single cycle and records what the spec says it must produce.
    task automatic issue_op(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [2:0] sew, input logic [6:0] vl, input logic [6:0] vstart,
                            input logic [4:0] dest, input logic [15:0] wen, input logic clr);
        int          eb, lo, hi;
        logic [15:0] m;
        logic [127:0] sdata, alu, ld_exp;
        logic [31:0] w;
        logic [3:0]  be;
        wait_not_stalled();
        sdata = {$urandom, $urandom, $urandom, $urandom};
        alu   = {$urandom, $urandom, $urandom, $urandom};
        valid_exe = 1'b1; is_load_exe = ld; is_store_exe = st; clear_pipe = clr;
        addr_exe = addr; store_data_exe = sdata; alu_result_exe = alu;
        rf_wr_en_exe = wen; rf_wr_addr_exe = dest;
        vtype_exe = {3'($urandom_range(0, 7)), sew, 3'($urandom_range(0, 7))};
        vl_exe = vl; vstart_exe = vstart;
        if (!clr) begin
            if (!ld && !st) begin
                if (wen != 16'd0) exp_wb_q.push_back('{en: wen, addr: dest, data: alu});
            end else if (addr[1:0] != 2'b00) begin
                exp_err_q.push_back(1'b1);
            end else begin
                eb = 1 << sew;
                lo = int'(vstart) * eb;
                hi = int'(vl) * eb;
                if (hi > 16) hi = 16;
                ld_exp = '0;
                for (int i = 0; i < 16; i++) m[i] = (i >= lo) && (i < hi);
                for (int k = 0; k < 4; k++) begin
                    be = m[4*k +: 4];
                    if (be != 4'd0)
                        exp_bus_q.push_back('{addr: addr + 32'(4*k), be: be, we: st, wdata: sdata[32*k +: 32]});
                end
                for (int i = 0; i < 16; i++) begin
                    w = mem_word(addr + 32'(4*(i/4)));
                    if (m[i]) ld_exp[8*i +: 8] = w[8*(i%4) +: 8];
                end
                if (ld && m != 16'd0) exp_wb_q.push_back('{en: m, addr: dest, data: ld_exp});
            end
        end
        @(posedge clk); #1;
        valid_exe = 1'b0; is_load_exe = 1'b0; is_store_exe = 1'b0; clear_pipe = 1'b0;
    endtask

    task automatic wait_idle();
        wait_not_stalled();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic set_delays(input int gmin, input int gmax, input int rmin, input int rmax);
        gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int stall_cycles;
        int base_gnt;
        int guard;
        logic [2:0] r_sew;
        int kind;
        logic [31:0] r_addr;

        rst = 1'b1; clear_pipe = 0; valid_exe = 0; is_load_exe = 0; is_store_exe = 0;
        addr_exe = '0; store_data_exe = '0; alu_result_exe = '0; rf_wr_en_exe = '0;
        rf_wr_addr_exe = '0; vtype_exe = '0; vl_exe = '0; vstart_exe = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 128'(state_dbg), 128'(IDLE));
        chk("reset_mem_req", 128'(mem_req), 128'd0);
        chk("reset_stall", 128'(lsu_stall), 128'd0);
        chk("reset_wr_en", 128'(rf_wr_en_mem), 128'd0);
        chk("reset_err", 128'(misaligned_err), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SEW=32 load of four full beats, immediate grant, rvalid one cycle later.
        set_delays(0, 0, 0, 0);
        issue_op(1, 0, 32'h100, 3'd2, 7'd4, 7'd0, 5'd3, 16'h0, 0);
        wait_idle();

        // SEW=8 store of six bytes: two beats, stall drops right after the second grant.
        issue_op(0, 1, 32'h0, 3'd0, 7'd6, 7'd0, 5'd0, 16'h0, 0);
        stall_cycles = 0;
        guard = 0;
        while (lsu_stall && guard < 50) begin
            stall_cycles++; guard++;
            @(posedge clk); #1;
        end
        chk("store_stall_cycles", 128'(stall_cycles), 128'd2);
        chk("store_beats_done", 128'(exp_bus_q.size()), 128'd0);
        wait_idle();

        // SEW=16 load with vstart=2 and slow grants: beat 0 skipped, request held stable.
        set_delays(3, 3, 0, 1);
        issue_op(1, 0, 32'h2000, 3'd1, 7'd8, 7'd2, 5'd9, 16'h0, 0);
        wait_idle();
        set_delays(0, 0, 0, 0);

        // Misaligned load: one error pulse, no traffic.
        issue_op(1, 0, 32'h102, 3'd2, 7'd4, 7'd0, 5'd4, 16'h0, 0);
        chk("misaligned_pulse", 128'(misaligned_err), 128'd1);
        chk("misaligned_no_req", 128'(mem_req), 128'd0);
        chk("misaligned_wr_en", 128'(rf_wr_en_mem), 128'd0);
        @(posedge clk); #1;
        chk("misaligned_one_cycle", 128'(misaligned_err), 128'd0);

        // vl=0 load completes without stalling.
        issue_op(1, 0, 32'h300, 3'd2, 7'd0, 7'd0, 5'd5, 16'h0, 0);
        chk("vl0_no_stall", 128'(lsu_stall), 128'd0);
        chk("vl0_wr_en", 128'(rf_wr_en_mem), 128'd0);

        // Flushed op is dropped entirely.
        issue_op(1, 0, 32'h400, 3'd2, 7'd4, 7'd0, 5'd6, 16'h0, 1);
        chk("flush_no_stall", 128'(lsu_stall), 128'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset while waiting for the third beat's read data.
        set_delays(0, 0, 6, 6);
        base_gnt = gnt_seen;
        issue_op(1, 0, 32'h500, 3'd2, 7'd4, 7'd0, 5'd7, 16'h0, 0);
        guard = 0;
        while (!(gnt_seen == base_gnt + 3 && state_dbg == WAIT) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        chk("reach_wait_beat2", 128'(guard < 200), 128'd1);
        rst = 1'b1;
        exp_bus_q.delete();
        exp_wb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_state", 128'(state_dbg), 128'(IDLE));
        chk("rst_mid_outputs", {mem_req, mem_we, lsu_stall, misaligned_err, mem_be, mem_addr, mem_wdata},
            128'd0);
        chk("rst_mid_wb", {rf_wr_en_mem, rf_wr_addr_mem}, 128'd0);
        chk("rst_mid_wdata", rf_wr_data_mem, 128'd0);
        set_delays(0, 0, 0, 0);
        issue_op(0, 0, 32'h0, 3'd0, 7'd0, 7'd0, 5'd17, 16'hBEEF, 0);
        chk("alu_latency_en", 128'(rf_wr_en_mem), 128'(16'hBEEF));
        chk("alu_latency_addr", 128'(rf_wr_addr_mem), 128'd17);
        wait_idle();

        // Randomized mix.
        set_delays(0, 3, 0, 3);
        for (int n = 0; n < 200; n++) begin
            kind   = $urandom_range(0, 9);
            r_sew  = 3'($urandom_range(0, 3));
            r_addr = $urandom & 32'hFFFF_FFFC;
            if (kind == 9) r_addr = r_addr | 32'($urandom_range(1, 3));
            issue_op(kind >= 2 && kind <= 5 || (kind == 9 && r_addr[2]),
                     kind >= 6 && kind <= 8 || (kind == 9 && !r_addr[2]),
                     r_addr, r_sew, 7'($urandom_range(0, 17)), 7'($urandom_range(0, 6)),
                     5'($urandom_range(0, 31)), 16'($urandom), ($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge clk);
        #1;

        chk("bus_queue_empty", 128'(exp_bus_q.size()), 128'd0);
        chk("wb_queue_empty", 128'(exp_wb_q.size()), 128'd0);
        chk("err_queue_empty", 128'(exp_err_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_v_lsu.md
RISCV_V_LSU -- requirements
Module: riscv_v_lsu

Interface
REQ-001 Parameter: BEAT_WIDTH, default 32, data-bus beat width in bits; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clear_pipe  in  1  flush; drops an op that has not yet been accepted.
REQ-005 valid_exe / is_load_exe / is_store_exe  in  1 each  op valid, unit-stride load, unit-stride store.
REQ-006 addr_exe  in  32  base byte address from the scalar register file.
REQ-007 store_data_exe  in  128  store source vector.
REQ-008 alu_result_exe  in  128  non-memory result.
REQ-009 rf_wr_en_exe  in  16  byte write enables.
REQ-010 rf_wr_addr_exe  in  5  destination register.
REQ-011 vtype_exe  in  9  vtype; SEW field is [5:3].
REQ-012 vl_exe, vstart_exe  in  7 each  element count and start element.
REQ-013 rf_wr_en_mem  out  16  byte write enables to write-back.
REQ-014 rf_wr_addr_mem  out  5  destination register to write-back.
REQ-015 rf_wr_data_mem  out  128  write data to write-back.
REQ-016 lsu_stall  out  1  upstream holds the exe stage while high.
REQ-017 misaligned_err  out  1  one-cycle error pulse.
REQ-018 mem_req / mem_we  out  1 each  request, write.
REQ-019 mem_addr  out  32  beat address.
REQ-020 mem_wdata  out  32  beat write data.
REQ-021 mem_be  out  4  beat byte enables.
REQ-022 mem_gnt / mem_rvalid  in  1 each  request granted, read data valid.
REQ-023 mem_rdata  in  32  read data.

Function
REQ-024 Op acceptance: an op is accepted in IDLE when valid_exe=1 and clear_pipe=0; clear_pipe=1 drops the op with no effect.
REQ-025 Non-memory ops: rf_wr_en_mem, rf_wr_addr_mem and rf_wr_data_mem are the registered exe values, 1-cycle latency.
REQ-026 Element bytes: eb = 1<<SEW.
REQ-027 Active byte i (0..15): i >= vstart*eb and i < min(vl*eb,16).
REQ-028 Beats: beat k covers bytes 4k..4k+3 at address addr_exe+4k; mem_be is that beat's active-byte slice.
REQ-029 Beats with mem_be=0 are skipped; active beats issue in ascending k.
REQ-030 If addr_exe[1:0]!=0, the op is dropped and misaligned_err pulses the next cycle; no bus traffic, no register write.
REQ-031 If no bytes are active, the op completes with no bus traffic; a load writes rf_wr_en_mem=0.
REQ-032 FSM states are IDLE, REQ and WAIT.
REQ-033 IDLE->REQ when a memory op is accepted with at least one active beat.
REQ-034 In REQ, mem_req=1 and mem_addr/mem_be/mem_wdata/mem_we are held stable until mem_gnt.
REQ-035 Store in REQ on mem_gnt: go to REQ for the next active beat, else to IDLE.
REQ-036 Load in REQ on mem_gnt: go to WAIT.
REQ-037 In WAIT on mem_rvalid: capture mem_rdata into the enabled byte lanes, then go to REQ for the next active beat, else to IDLE.
REQ-038 Only one request is outstanding at a time; mem_req=0 in WAIT and in IDLE.
REQ-039 lsu_stall = (state==REQ || state==WAIT).
REQ-040 Load completion: in the cycle after the final rvalid, rf_wr_en_mem = active-byte mask, rf_wr_addr_mem = captured destination, rf_wr_data_mem = assembled data; inactive bytes are 0.
REQ-041 Store completion: rf_wr_en_mem=0.
REQ-042 While REQ or WAIT, rf_wr_en_mem=0.
REQ-043 clear_pipe is ignored once an op has left IDLE; issued bus transactions complete.
REQ-044 A simultaneous mem_gnt and mem_rvalid in REQ is illegal for this protocol; rvalid is only sampled in WAIT.

Reset
REQ-045 rst=1 forces IDLE with every output 0, including mem_req on the next edge.
REQ-046 Reset mid-operation abandons the op; the bus slave tolerates dropped requests.

Structure
REQ-047 riscv_v_pkg carries RISCV_V_MEM_BEAT_WIDTH=32, RISCV_V_MEM_NUM_BEATS=4 and the lsu_state_t enum {IDLE,REQ,WAIT}.
REQ-048 Byte-mask generation (SEW, vl, vstart -> 16-bit mask) lives in sub-module riscv_v_lsu_byte_mask.
REQ-049 The block sits downstream of the vector execute stage, in place of the memory-stage stub.

Verification
REQ-050 Load, SEW=32, vl=4, vstart=0, addr 0x100, gnt immediate, rvalid 1 cycle later -> 4 beats at 0x100..0x10C with be=F; rf_wr_en_mem=FFFF; data assembled in order.
REQ-051 Store, SEW=8, vl=6 -> beats at 0x0 with be=F and 0x4 with be=3; beats 2-3 skipped; lsu_stall falls after the second gnt.
REQ-052 Load, SEW=16, vl=8, vstart=2, gnt delayed 3 cycles per beat -> bytes 4..15 enabled, beat 0 skipped, mem_addr/mem_be stable during the delay.
REQ-053 Load with addr 0x102 -> misaligned_err pulses once, mem_req stays 0, rf_wr_en_mem=0.
REQ-054 vl=0 load -> no mem_req, no stall, rf_wr_en_mem=0; separately, clear_pipe with an offered op -> op dropped.
REQ-055 rst during WAIT of beat 2 -> next cycle IDLE, all outputs 0; a following non-memory op passes through with 1-cycle latency.
